pad_ring_seq: RTL and testbench

- Power-up and reset sequencer for the chip pad ring and core.
- Synchronises the external reset and the IO-supply power-ok level.
- Enables pad input buffers, then pad output drivers, in a fixed order; only then releases the core reset.
- Handles software-requested core reset and IO power-fail teardown. Sits in the chip top, between the pad ring and the RISC-V core/SoC reset tree.

---
 rtl/pad_ring_pkg.sv | 44 ++++
 rtl/pad_ring_seq_sync_2ff.sv | 20 ++
 rtl/pad_ring_seq.sv | 122 ++++++++++++
 tb/tb_pad_ring_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pad_ring_pkg.sv
// Shared types and constants for the pad-ring power-up/reset sequencer.
package pad_ring_pkg;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_WAIT_PWR = 3'd1,
    S_PAD_IE   = 3'd2,
    S_PAD_OE   = 3'd3,
    S_RUN      = 3'd4,
    S_SW_RST   = 3'd5,
    S_PWR_FAIL = 3'd6
  } state_e;

  localparam int DEF_SYNC_STAGES       = 2;
  localparam int DEF_PWR_STABLE_CYCLES = 1024;
  localparam int DEF_PAD_SETTLE_CYCLES = 16;
  localparam int DEF_SW_RST_CYCLES     = 32;
  localparam int DEF_CNT_W             = 11;

  localparam int RC_SW_BIT  = 0;
  localparam int RC_PWR_BIT = 1;

  typedef struct packed {
    logic ie;
    logic oe;
    logic core_rst_n;
  } pad_ctl_t;

  // Pad/core controls for a given state; illegal encodings yield reset values.
  function automatic pad_ctl_t pad_decode(input state_e s);
    pad_ctl_t c;
    c = '0;
    case (s)
      S_PAD_IE:   c.ie = 1'b1;
      S_PAD_OE:   begin c.ie = 1'b1; c.oe = 1'b1; end
      S_RUN:      begin c.ie = 1'b1; c.oe = 1'b1; c.core_rst_n = 1'b1; end
      S_SW_RST:   begin c.ie = 1'b1; c.oe = 1'b1; end
      S_PWR_FAIL: c.ie = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pad_ring_seq_sync_2ff.sv
// Multi-flop bit synchroniser with asynchronous active-low reset (output resets to 0).
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* dont_touch = "true" *) logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= '0;
    else         r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/pad_ring_seq.sv
// Pad-ring power-up sequencer: IE, then OE, then core reset release; SW reset and power-fail teardown.
// Optional sticky reset-cause register enabled by defining KMIE_RST_CAUSE_EN.
module pad_ring_seq
  import pad_ring_pkg::*;
#(
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int PWR_STABLE_CYCLES = DEF_PWR_STABLE_CYCLES,
  parameter int PAD_SETTLE_CYCLES = DEF_PAD_SETTLE_CYCLES,
  parameter int SW_RST_CYCLES     = DEF_SW_RST_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       io_pwr_ok_i,
  input  logic       sw_rst_req_i,
  output logic       pad_ie_en_o,
  output logic       pad_oe_en_o,
  output logic       core_rst_no,
  output logic [2:0] seq_state_o
`ifdef KMIE_RST_CAUSE_EN
  ,
  output logic [1:0] rst_cause_o,
  input  logic       rst_cause_clr_i
`endif
);

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PAD_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RST_CYCLES - 1);

  logic w_rst_sync_n, w_pwr_ok_s;

  (* dont_touch = "true" *)
  sync_2ff #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(1'b1), .q_o(w_rst_sync_n)
  );

  (* dont_touch = "true" *)
  sync_2ff #(.STAGES(SYNC_STAGES)) u_pwr_sync (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(io_pwr_ok_i), .q_o(w_pwr_ok_s)
  );

  state_e           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  pad_ctl_t         r_ctl, w_ctl_nxt;

  // Counter restarts from 0 on every state change; it only advances while dwelling.
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = '0;
    case (r_state)
      S_RESET:    w_nxt = S_WAIT_PWR;
      S_WAIT_PWR: begin
        if (w_pwr_ok_s) begin
          if (r_cnt == PWR_LAST) w_nxt = S_PAD_IE;
          else                   w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PAD_IE: begin
        if (!w_pwr_ok_s)              w_nxt = S_PWR_FAIL;
        else if (r_cnt == SETTLE_LAST) w_nxt = S_PAD_OE;
        else                           w_cnt_nxt = r_cnt + 1'b1;
      end
      S_PAD_OE: begin
        if (!w_pwr_ok_s)              w_nxt = S_PWR_FAIL;
        else if (r_cnt == SETTLE_LAST) w_nxt = S_RUN;
        else                           w_cnt_nxt = r_cnt + 1'b1;
      end
      S_RUN: begin
        if (!w_pwr_ok_s)       w_nxt = S_PWR_FAIL;
        else if (sw_rst_req_i) w_nxt = S_SW_RST;
      end
      S_SW_RST: begin
        if (!w_pwr_ok_s)           w_nxt = S_PWR_FAIL;
        else if (r_cnt == SW_LAST) w_nxt = S_RUN;
        else                       w_cnt_nxt = r_cnt + 1'b1;
      end
      S_PWR_FAIL: begin
        if (r_cnt == SETTLE_LAST) w_nxt = S_WAIT_PWR;
        else                      w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_nxt = S_RESET;
    endcase
    w_ctl_nxt = pad_decode(w_nxt);
  end

  always_ff @(posedge clk_i or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_ctl   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctl   <= w_ctl_nxt;
    end
  end

  assign pad_ie_en_o = r_ctl.ie;
  assign pad_oe_en_o = r_ctl.oe;
  assign core_rst_no = r_ctl.core_rst_n;
  assign seq_state_o = r_state;

`ifdef KMIE_RST_CAUSE_EN
  logic [1:0] r_rst_cause, w_cause_set;

  always_comb begin
    w_cause_set             = '0;
    w_cause_set[RC_SW_BIT]  = (w_nxt == S_SW_RST)   && (r_state != S_SW_RST);
    w_cause_set[RC_PWR_BIT] = (w_nxt == S_PWR_FAIL) && (r_state != S_PWR_FAIL);
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rst_cause <= '0;
    else         r_rst_cause <= (rst_cause_clr_i ? 2'b00 : r_rst_cause) | w_cause_set;
  end

  assign rst_cause_o = r_rst_cause;
`endif

endmodule

// File: tb/tb_pad_ring_seq.sv
// Scenario bench for pad_ring_seq with small cycle parameters and randomized timing.
module tb_pad_ring_seq;

  localparam int SYNC = 2, PWR = 8, SETTLE = 4, SWR = 4;

  logic clk = 1'b0, rst_n = 1'b0, pwr_ok = 1'b1, sw_req = 1'b0;
  logic ie, oe, core_n;
  logic [2:0] state;
`ifdef KMIE_RST_CAUSE_EN
  logic [1:0] cause;
  logic       cause_clr = 1'b0;
`endif

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pad_ring_seq #(
    .SYNC_STAGES(SYNC), .PWR_STABLE_CYCLES(PWR), .PAD_SETTLE_CYCLES(SETTLE),
    .SW_RST_CYCLES(SWR), .CNT_W(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .io_pwr_ok_i(pwr_ok), .sw_rst_req_i(sw_req),
    .pad_ie_en_o(ie), .pad_oe_en_o(oe), .core_rst_no(core_n), .seq_state_o(state)
`ifdef KMIE_RST_CAUSE_EN
    , .rst_cause_o(cause), .rst_cause_clr_i(cause_clr)
`endif
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ie;
      1:       return oe;
      default: return core_n;
    endcase
  endfunction

  // Steps until the selected output equals val; n = steps taken, -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sig(sel) === val) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; pwr_ok = 1'b1;
    repeat (3) step();
    n_cmp++; if (ie !== 1'b0)    begin n_err++; $display("FAIL rst_ie got %b exp 0", ie); end
    n_cmp++; if (oe !== 1'b0)    begin n_err++; $display("FAIL rst_oe got %b exp 0", oe); end
    n_cmp++; if (core_n !== 1'b0) begin n_err++; $display("FAIL rst_core got %b exp 0", core_n); end
    n_cmp++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
    rst_n = 1'b1;
    wait_sig(0, 1'b1, 60, n);
    n_cmp++; if (n !== SYNC + 1 + PWR) begin n_err++; $display("FAIL pu_ie_lat got %0d exp %0d", n, SYNC + 1 + PWR); end
    n_cmp++; if (state !== 3'd2) begin n_err++; $display("FAIL pu_state_ie got %0d exp 2", state); end
    wait_sig(1, 1'b1, 30, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL pu_oe_lat got %0d exp %0d", n, SETTLE); end
    wait_sig(2, 1'b1, 30, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL pu_core_lat got %0d exp %0d", n, SETTLE); end
    n_cmp++; if (state !== 3'd4 || ie !== 1'b1 || oe !== 1'b1) begin
      n_err++; $display("FAIL pu_run got st=%0d ie=%b oe=%b exp st=4 ie=1 oe=1", state, ie, oe); end
  endtask

  // Pulse sw_req once, then count core-reset-low samples until release.
  task automatic sw_pulse_count(input int retrig_at, output int low, output int pad_drops);
    sw_req = 1'b1; step(); sw_req = 1'b0;
    low = (core_n === 1'b0) ? 1 : 0;
    pad_drops = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == retrig_at) sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      if (core_n !== 1'b0) break;
      low++;
      if (ie !== 1'b1 || oe !== 1'b1) pad_drops++;
    end
  endtask

  task automatic test_sw_rst();
    int low, drops, j;
    repeat ($urandom_range(1, 10)) step();
    j = $urandom_range(1, 3);
    sw_pulse_count(j, low, drops);
    n_cmp++; if (low !== SWR)  begin n_err++; $display("FAIL sw_low_len got %0d exp %0d", low, SWR); end
    n_cmp++; if (drops !== 0)  begin n_err++; $display("FAIL sw_pads_held got %0d drops exp 0", drops); end
    n_cmp++; if (state !== 3'd4) begin n_err++; $display("FAIL sw_back_run got %0d exp 4", state); end
  endtask

  task automatic test_back_to_back();
    int low, drops;
    sw_pulse_count(0, low, drops);
    n_cmp++; if (low !== SWR) begin n_err++; $display("FAIL b2b_low_len got %0d exp %0d", low, SWR); end
    n_cmp++; if (drops !== 0) begin n_err++; $display("FAIL b2b_pads_held got %0d exp 0", drops); end
  endtask

  task automatic test_pwr_fail();
    int n;
    repeat ($urandom_range(0, 5)) step();
    pwr_ok = 1'b0;
    wait_sig(2, 1'b0, 20, n);
    n_cmp++; if (n !== SYNC + 1) begin n_err++; $display("FAIL pf_core_lat got %0d exp %0d", n, SYNC + 1); end
    n_cmp++; if (oe !== 1'b0 || ie !== 1'b1 || state !== 3'd6) begin
      n_err++; $display("FAIL pf_teardown got oe=%b ie=%b st=%0d exp oe=0 ie=1 st=6", oe, ie, state); end
    wait_sig(0, 1'b0, 20, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL pf_ie_lat got %0d exp %0d", n, SETTLE); end
    repeat ($urandom_range(3, 20)) step();
    n_cmp++; if (state !== 3'd1 || ie !== 1'b0 || core_n !== 1'b0) begin
      n_err++; $display("FAIL pf_wait got st=%0d ie=%b core=%b exp st=1 ie=0 core=0", state, ie, core_n); end
  endtask

  // Power returns, glitches once mid-count; full sequence must replay from the glitch.
  task automatic test_glitch();
    int n, d;
    d = $urandom_range(1, 5);
    pwr_ok = 1'b1;
    repeat (d) step();
    pwr_ok = 1'b0; step(); pwr_ok = 1'b1;
    wait_sig(0, 1'b1, 60, n);
    n_cmp++; if (n !== SYNC + PWR) begin n_err++; $display("FAIL gl_ie_lat got %0d exp %0d (d=%0d)", n, SYNC + PWR, d); end
    wait_sig(1, 1'b1, 30, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL gl_oe_lat got %0d exp %0d", n, SETTLE); end
    wait_sig(2, 1'b1, 30, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL gl_core_lat got %0d exp %0d", n, SETTLE); end
  endtask

  task automatic test_same_cycle();
    int n;
`ifdef KMIE_RST_CAUSE_EN
    cause_clr = 1'b1; step(); cause_clr = 1'b0;
    n_cmp++; if (cause !== 2'b00) begin n_err++; $display("FAIL cause_clr got %b exp 00", cause); end
`endif
    repeat ($urandom_range(1, 6)) step();
    pwr_ok = 1'b0;
    repeat (SYNC) step();
    sw_req = 1'b1; step(); sw_req = 1'b0;
    n_cmp++; if (state !== 3'd6) begin n_err++; $display("FAIL sc_state got %0d exp 6", state); end
    n_cmp++; if (core_n !== 1'b0 || oe !== 1'b0) begin
      n_err++; $display("FAIL sc_outs got core=%b oe=%b exp 0 0", core_n, oe); end
`ifdef KMIE_RST_CAUSE_EN
    n_cmp++; if (cause !== 2'b10) begin n_err++; $display("FAIL sc_cause got %b exp 10", cause); end
`endif
    wait_sig(0, 1'b0, 20, n);
    n_cmp++; if (n !== SETTLE) begin n_err++; $display("FAIL sc_ie_lat got %0d exp %0d", n, SETTLE); end
    pwr_ok = 1'b1;
    wait_sig(2, 1'b1, 100, n);
    n_cmp++; if (n !== SYNC + PWR + 2 * SETTLE) begin
      n_err++; $display("FAIL sc_replay got %0d exp %0d", n, SYNC + PWR + 2 * SETTLE); end
  endtask

  task automatic test_async_reset();
    int n;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    wait_sig(1, 1'b1, 60, n);
    n_cmp++; if (n !== SYNC + 1 + PWR + SETTLE) begin
      n_err++; $display("FAIL ar_oe_lat got %0d exp %0d", n, SYNC + 1 + PWR + SETTLE); end
    repeat ($urandom_range(0, 2)) step();
    n_cmp++; if (state !== 3'd3) begin n_err++; $display("FAIL ar_in_oe got %0d exp 3", state); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({ie, oe, core_n, state} !== 6'b0) begin
      n_err++; $display("FAIL ar_async got ie=%b oe=%b core=%b st=%0d exp all 0", ie, oe, core_n, state); end
    repeat (2) step();
    rst_n = 1'b1;
    wait_sig(0, 1'b1, 60, n);
    n_cmp++; if (n !== SYNC + 1 + PWR) begin n_err++; $display("FAIL ar_restart got %0d exp %0d", n, SYNC + 1 + PWR); end
  endtask

  initial begin
    test_reset();
    test_sw_rst();
    test_back_to_back();
    test_pwr_fail();
    test_glitch();
    test_same_cycle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
